// File: rtl/cmplx_mul_pipe.sv
// Three-stage pipelined signed complex multiplier y = a*b or a*conj(b), with
// Q-format rescaling, optional rounding and saturation, and valid/ready flow control.
module cmplx_mul_pipe #(
    parameter int DATA_W   = 16,
    parameter int TW_W     = 16,
    parameter int OUT_W    = 16,
    parameter int FRAC_W   = 15,
    parameter int ROUND_EN = 1,
    parameter int SAT_EN   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [TW_W-1:0]   b_re,
    input  logic signed [TW_W-1:0]   b_im,
    input  logic                     conj_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  y_re,
    output logic signed [OUT_W-1:0]  y_im,
    output logic                     ovf,
    output logic                     ovf_sticky,
    input  logic                     ovf_clr
);

    // BW carries the negated twiddle so -(-2^(TW_W-1)) stays exact.
    localparam int BW = TW_W + 1;
    localparam int PW = DATA_W + BW;
    localparam int FW = PW + 1;
    localparam int SW = FW + 1 - FRAC_W;
    localparam int EW = ((SW > OUT_W) ? SW : OUT_W) + 1;
    localparam int XW = EW + FRAC_W;

    function automatic logic signed [EW-1:0] round_shift(input logic signed [FW-1:0] x);
        logic signed [XW-1:0] xe;
        logic signed [XW-1:0] rc;
        xe = {{(XW-FW){x[FW-1]}}, x};
        rc = '0;
        rc[FRAC_W-1] = (ROUND_EN != 0);
        xe = xe + rc;
        xe = xe >>> FRAC_W;
        return xe[EW-1:0];
    endfunction

    // Returns {overflow, result}; overflow means the value did not fit in OUT_W.
    function automatic logic [OUT_W:0] fit_out(input logic signed [EW-1:0] v);
        logic [EW-1:0]    maxv;
        logic [OUT_W-1:0] y;
        logic             fits;
        maxv = '0;
        maxv[OUT_W-2:0] = '1;
        fits = (v[EW-1:OUT_W-1] == {(EW-OUT_W+1){v[EW-1]}});
        y    = v[OUT_W-1:0];
        if (!fits && (SAT_EN != 0)) begin
            y = v[EW-1] ? ~maxv[OUT_W-1:0] : maxv[OUT_W-1:0];
        end
        return {~fits, y};
    endfunction

    logic en;

    logic signed [DATA_W-1:0] ar_p1_q, ai_p1_q;
    logic signed [BW-1:0]     br_p1_q, bi_p1_q;
    logic signed [BW-1:0]     bi_p1_d;
    logic                     vld_p1_q;

    logic signed [PW-1:0]     rr_p2_q, ii_p2_q, ri_p2_q, ir_p2_q;
    logic                     vld_p2_q;

    logic signed [FW-1:0]     re_full, im_full;
    logic [OUT_W:0]           re_fit, im_fit;
    logic signed [OUT_W-1:0]  y_re_d, y_im_d, y_re_q, y_im_q;
    logic                     ovf_d, ovf_q, vld_p3_q;
    logic                     sticky_d, sticky_q;

    assign en       = !vld_p3_q || out_ready;
    assign in_ready = en;

    // S1: input capture with optional twiddle conjugation
    assign bi_p1_d = conj_b ? -BW'(b_im) : BW'(b_im);

    always_ff @(posedge clk) begin
        if (en) begin
            ar_p1_q <= a_re;
            ai_p1_q <= a_im;
            br_p1_q <= BW'(b_re);
            bi_p1_q <= bi_p1_d;
        end
    end

    // S2: four full-precision partial products
    always_ff @(posedge clk) begin
        if (en) begin
            rr_p2_q <= PW'(ar_p1_q) * PW'(br_p1_q);
            ii_p2_q <= PW'(ai_p1_q) * PW'(bi_p1_q);
            ri_p2_q <= PW'(ar_p1_q) * PW'(bi_p1_q);
            ir_p2_q <= PW'(ai_p1_q) * PW'(br_p1_q);
        end
    end

    // S3: combine, rescale and clamp/wrap into the output registers
    always_comb begin
        re_full = FW'(rr_p2_q) - FW'(ii_p2_q);
        im_full = FW'(ri_p2_q) + FW'(ir_p2_q);
        re_fit  = fit_out(round_shift(re_full));
        im_fit  = fit_out(round_shift(im_full));
        y_re_d  = re_fit[OUT_W-1:0];
        y_im_d  = im_fit[OUT_W-1:0];
        ovf_d   = vld_p2_q && (re_fit[OUT_W] || im_fit[OUT_W]);
    end

    assign sticky_d = (vld_p3_q && out_ready && ovf_q) || (sticky_q && !ovf_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            y_re_q   <= '0;
            y_im_q   <= '0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
            if (en) begin
                vld_p1_q <= in_valid;
                vld_p2_q <= vld_p1_q;
                vld_p3_q <= vld_p2_q;
                y_re_q   <= y_re_d;
                y_im_q   <= y_im_d;
                ovf_q    <= ovf_d;
            end
        end
    end

    assign out_valid  = vld_p3_q;
    assign y_re       = y_re_q;
    assign y_im       = y_im_q;
    assign ovf        = ovf_q;
    assign ovf_sticky = sticky_q;

endmodule

// File: doc/cmplx_mul_pipe.md
Name: cmplx_mul_pipe

Overview:
- Pipelined, parametrised signed complex multiplier for the FFT butterfly datapath. It computes y = a * b, or a * conj(b) when conj_b is set.
- Scales the product back to Q-format, with selectable rounding and optional saturation.
- Sits between the butterfly add/sub stage and the twiddle ROM. Uses a valid/ready stream handshake so the stage can stall with the rest of the FFT pipe.

Parameters:
DATA_W, 16, signed width of a_re/a_im
TW_W, 16, signed width of b_re/b_im (twiddle)
OUT_W, 16, signed width of y_re/y_im
FRAC_W, 15, right-shift applied to full-precision products (twiddle fraction bits); 1 <= FRAC_W < DATA_W+TW_W
ROUND_EN, 1, 1 = round half toward +inf, 0 = truncate (floor)
SAT_EN, 1, 1 = saturate to OUT_W range, 0 = wrap (keep low OUT_W bits)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  block accepts input this cycle
a_re  in  DATA_W  signed real part of data
a_im  in  DATA_W  signed imag part of data
b_re  in  TW_W  signed real part of twiddle
b_im  in  TW_W  signed imag part of twiddle
conj_b  in  1  1 = use conj(b), sampled with the input
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts output
y_re  out  OUT_W  signed real result
y_im  out  OUT_W  signed imag result
ovf  out  1  this output sample saturated/wrapped in re or im
ovf_sticky  out  1  any overflow since reset/clear
ovf_clr  in  1  synchronous clear of ovf_sticky

Behaviour:
- Reset (async, rst_n=0): all stage valid bits, out_valid, y_re, y_im, ovf and ovf_sticky = 0. in_ready = 1 one cycle after rst_n deasserts. Reset mid-operation discards every in-flight sample; no partial output.
- Pipeline: 3 register stages, S1 input regs, S2 products, S3 combine/scale/output regs. Latency 3 cycles from accepted input to out_valid with out_ready held high. Throughput 1 sample/cycle.
- Advance enable: en = !out_valid | out_ready. All stages advance together when en=1 and hold all data/valid when en=0. in_ready = en (combinational from out_ready and out_valid).
- Transfer occurs on in_valid & in_ready, and on out_valid & out_ready. Bubbles propagate as valid=0 stages; they are not collapsed.
- While out_valid=1 and out_ready=0: y_re, y_im and ovf stay stable.
- S1: if conj_b, bi' = -b_im, computed at TW_W+1 bits so that -(-2^(TW_W-1)) is exact. Otherwise bi' = b_im.
- S2: four full-precision signed products: ar*br, ai*bi', ar*bi', ai*br.
- S3 arithmetic:
  - re_full = ar*br - ai*bi'; im_full = ar*bi' + ai*br. Width DATA_W+TW_W+2, no intermediate overflow.
  - If ROUND_EN, add 2^(FRAC_W-1) before shifting.
  - Then arithmetic shift right by FRAC_W.
- Saturation (SAT_EN=1): a result above 2^(OUT_W-1)-1 clamps to that value; a result below -2^(OUT_W-1) clamps to that value. ovf=1 if either part clamped.
- Wrap (SAT_EN=0): y takes the low OUT_W bits. ovf=1 if the discarded bits are not a sign extension.
- ovf is registered with y and valid only when out_valid=1. It is 0 for bubble stages.
- ovf_sticky: set when an output sample transfers with ovf=1. Cleared by ovf_clr. If set and clear happen in the same cycle, set wins.
- No internal state machine beyond the valid shift chain. Nothing depends on data history except ovf_sticky.

Test Plan (defaults):
1. Basic product: a=(16384,0), b=(16384,16384), conj_b=0, out_ready=1 -> 3 cycles later y=(8192,8192), ovf=0.
2. Conjugate: a=(0,16384), b=(16384,16384).
   - conj_b=0 -> y=(-8192,8192).
   - conj_b=1 -> y=(8192,8192).
3. Rounding: a=(1,0), b=(16384,0).
   - ROUND_EN=1 -> y_re=1.
   - ROUND_EN=0 -> y_re=0.
   - With a=(-1,0), b=(16384,0): ROUND_EN=1 -> y_re=0; ROUND_EN=0 -> y_re=-1.
4. Saturation: a=(-32768,0), b=(-32768,0) -> y=(32767,0), ovf=1, ovf_sticky=1 next cycle.
   - Repeat with SAT_EN=0 -> y_re=-32768, ovf=1.
   - Then pulse ovf_clr -> ovf_sticky=0.
5. Backpressure: stream 5 samples back-to-back, drop out_ready for 4 cycles after the first output.
   - in_ready must track en.
   - Outputs must hold stable during the stall.
   - All 5 results appear in order with none lost or duplicated.
6. Reset mid-stream: assert rst_n=0 with 3 samples in flight -> out_valid=0 and y=0 immediately. After release, no stale sample is ever output.
